// File: rtl/alu_seq_disp.sv
// rtl/alu_seq_disp.sv - multi-cycle ALU with start/done handshake and 4-digit 7-segment driver
//
// Purpose:
//   Accepts two unsigned W-bit operands and a 3-bit opcode on an init pulse,
//   computes add/sub/and/or/xor in one EXEC cycle, and mul (shift-add) or
//   div (restoring) in W EXEC cycles. Produces a 2*W-bit registered result
//   with neg/err flags, then shows the result as hex on a multiplexed display.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   portA, portB  W-bit unsigned operands, latched in IDLE on init
//   opcode        0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 reserved
//   init          start request, only looked at in IDLE
//   busy          high while the FSM is not in IDLE
//   done          one-cycle pulse while the FSM is in DONE
//   result        2*W-bit result, held until the next done
//   neg           sub result was negative (A < B)
//   err           divide by zero or reserved opcode
//   sseg[0:6]     segments a..g, active-low (combinational decode)
//   an[3:0]       digit anodes, active-low, an[0] = least-significant digit

module alu_seq_disp #(
    parameter int W            = 4,
    parameter int REFRESH_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     portA,
    input  logic [W-1:0]     portB,
    input  logic [2:0]       opcode,
    input  logic             init,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result,
    output logic             neg,
    output logic             err,
    output logic [0:6]       sseg,
    output logic [3:0]       an
);

    localparam int RW = 2 * W;
    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [2:0]        op_q;
    logic [CW-1:0]     cnt_q;

    // multiply: accumulator, left-shifting multiplicand, right-shifting multiplier
    logic [RW-1:0]     acc_q;
    logic [RW-1:0]     mcand_q;
    logic [W-1:0]      mplier_q;

    // divide: partial remainder and a register that starts as the dividend
    // and fills with quotient bits from the right as dividend bits leave
    logic [W-1:0]      rem_q;
    logic [W-1:0]      quo_q;

    logic              busy_q;
    logic              done_q;
    logic [RW-1:0]     result_q;
    logic              neg_q;
    logic              err_q;

    logic [REFRESH_BITS-1:0] presc_q;
    logic [1:0]        digit_q;
    logic [3:0]        an_q;

    // ------------------------------------------------------------------
    // Iterative step logic
    // ------------------------------------------------------------------
    logic [RW-1:0]     acc_d;
    logic [W:0]        div_shift;
    logic              div_ge;
    logic [W-1:0]      div_diff;
    logic [W-1:0]      rem_d;
    logic [W-1:0]      quo_d;
    logic              is_iter;
    logic              last_iter;

    always_comb begin
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        div_shift = {rem_q, quo_q[W-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        // When div_ge holds the true difference is below 2**W, so a W-bit
        // subtraction of the low bits gives it exactly.
        div_diff  = div_shift[W-1:0] - b_q;
        rem_d     = div_ge ? div_diff : div_shift[W-1:0];
        quo_d     = {quo_q[W-2:0], div_ge};
        is_iter   = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
        last_iter = (cnt_q == CW'(W - 1));
    end

    // ------------------------------------------------------------------
    // Single-cycle results (also covers div-by-zero and reserved opcode)
    // ------------------------------------------------------------------
    logic [RW-1:0]     res1;
    logic              neg1;
    logic              err1;

    always_comb begin
        res1 = '0;
        neg1 = 1'b0;
        err1 = 1'b0;
        case (op_q)
            OP_ADD: res1 = RW'(a_q) + RW'(b_q);
            OP_SUB: begin
                res1 = RW'(a_q) - RW'(b_q);
                neg1 = (a_q < b_q);
            end
            OP_DIV: begin
                res1 = '1;
                err1 = 1'b1;
            end
            OP_AND: res1 = RW'(a_q & b_q);
            OP_OR:  res1 = RW'(a_q | b_q);
            OP_XOR: res1 = RW'(a_q ^ b_q);
            default: begin
                res1 = '0;
                err1 = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (init) begin
                        a_q      <= portA;
                        b_q      <= portB;
                        op_q     <= opcode;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mcand_q  <= RW'(portA);
                        mplier_q <= portB;
                        rem_q    <= '0;
                        quo_q    <= portA;
                        busy_q   <= 1'b1;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_iter) begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        rem_q    <= rem_d;
                        quo_q    <= quo_d;
                        cnt_q    <= cnt_q + 1'b1;
                        if (last_iter) begin
                            // Final step result goes straight to the output
                            // so DONE is entered on the W-th EXEC edge.
                            result_q <= (op_q == OP_MUL) ? acc_d : {rem_d, quo_d};
                            neg_q    <= 1'b0;
                            err_q    <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end else begin
                        result_q <= res1;
                        neg_q    <= neg1;
                        err_q    <= err1;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display refresh: free-running prescaler, digit advances on wrap
    // ------------------------------------------------------------------
    logic [1:0] digit_nx;
    logic [3:0] an_nx;

    always_comb begin
        digit_nx = digit_q + 2'd1;
        case (digit_nx)
            2'd0:    an_nx = 4'b1110;
            2'd1:    an_nx = 4'b1101;
            2'd2:    an_nx = 4'b1011;
            default: an_nx = 4'b0111;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            digit_q <= 2'd0;
            an_q    <= 4'b1110;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) begin
                digit_q <= digit_nx;
                an_q    <= an_nx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment decode; nibbles above the result width read as zero
    // ------------------------------------------------------------------
    logic [15:0] res_ext;
    logic [3:0]  nibble;
    logic [6:0]  seg_n;

    always_comb begin
        res_ext = 16'(result_q);
        case (digit_q)
            2'd0:    nibble = res_ext[3:0];
            2'd1:    nibble = res_ext[7:4];
            2'd2:    nibble = res_ext[11:8];
            default: nibble = res_ext[15:12];
        endcase
        // bit 6 = segment a ... bit 0 = segment g, 0 = lit
        case (nibble)
            4'h0:    seg_n = 7'b0000001;
            4'h1:    seg_n = 7'b1001111;
            4'h2:    seg_n = 7'b0010010;
            4'h3:    seg_n = 7'b0000110;
            4'h4:    seg_n = 7'b1001100;
            4'h5:    seg_n = 7'b0100100;
            4'h6:    seg_n = 7'b0100000;
            4'h7:    seg_n = 7'b0001111;
            4'h8:    seg_n = 7'b0000000;
            4'h9:    seg_n = 7'b0000100;
            4'hA:    seg_n = 7'b0001000;
            4'hB:    seg_n = 7'b1100000;
            4'hC:    seg_n = 7'b0110001;
            4'hD:    seg_n = 7'b1000010;
            4'hE:    seg_n = 7'b0110000;
            default: seg_n = 7'b0111000;
        endcase
    end

    assign sseg   = seg_n;
    assign an     = an_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign neg    = neg_q;
    assign err    = err_q;

endmodule
